mult4_prod_accum: RTL and testbench

Downstream consumer of the 4-bit combinational multiplier's 8-bit product P. It registers a stream of products under a valid/ready handshake and accumulates them into a saturating sum over a frame. A frame closes on an explicit last flag or after FRAME_LEN products. The frame result is then presented on a held output with valid/ready. Used for dot-product and characterisation runs over the 4-bit multiplier variants.

---
 rtl/mult4_prod_accum.sv | 119 +++++++++++
 tb/tb_mult4_prod_accum.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult4_prod_accum.sv
// mult4_prod_accum
// Accumulates a stream of unsigned multiplier products into a saturating
// per-frame sum. A frame closes on in_last or after FRAME_LEN products.
// The frame result is then held on the outputs until downstream takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ACCUM | accepting products, in_ready=1, out_valid=0
// ST_HOLD  | frame result presented, in_ready=0, out_valid=1
//
// in_ready and out_valid come straight from the state register, so there
// is no combinational path from any input to any output.

module mult4_prod_accum #(
  parameter int PW        = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 16,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_sat
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CW-1:0]    LP_FRAME_LEN = CW'(FRAME_LEN);
  localparam logic [CW-1:0]    LP_CNT_ONE   = CW'(1);
  localparam logic [ACC_W-1:0] LP_ACC_MAX   = '1;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;
  logic [ACC_W-1:0] r_out_sum;
  logic [CW-1:0]    r_out_count;
  logic             r_out_sat;

  logic             w_accept;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sat_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_close;

  // Product acceptance is only possible while accumulating.
  assign w_accept = in_valid && (r_state == ST_ACCUM);

  // One extra bit catches the overflow; once saturated the accumulator sits
  // at all-ones, and any further non-zero product carries out again.
  assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, in_p};
  assign w_carry    = w_sum_ext[ACC_W];
  assign w_acc_next = w_carry ? LP_ACC_MAX : w_sum_ext[ACC_W-1:0];
  assign w_sat_next = r_sat | w_carry;
  assign w_cnt_next = r_cnt + LP_CNT_ONE;

  // Frame ends on an explicit last flag or when the length limit is hit.
  assign w_close = in_last || (w_cnt_next == LP_FRAME_LEN);

  // Frame FSM: accumulate, latch the result on close, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_close) begin
              r_out_sum   <= w_acc_next;
              r_out_count <= w_cnt_next;
              r_out_sat   <= w_sat_next;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_sat       <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= w_cnt_next;
              r_sat <= w_sat_next;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_mult4_prod_accum.sv
// Bench for mult4_prod_accum: two instances (ACC_W=16 and ACC_W=9) share
// one input stream; a frame-level model predicts handshakes and results.

module tb_mult4_prod_accum;

  localparam int PW = 8;
  localparam int FL = 16;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_p;
  logic          in_last;
  logic          out_ready;

  logic          a_in_ready, a_out_valid, a_out_sat;
  logic [15:0]   a_out_sum;
  logic [CW-1:0] a_out_count;
  logic          b_in_ready, b_out_valid, b_out_sat;
  logic [8:0]    b_out_sum;
  logic [CW-1:0] b_out_count;

  int n_pass  = 0;
  int n_total = 0;

  // frame-level model state, index 0 = ACC_W 16, index 1 = ACC_W 9
  bit          m_hold;
  int          m_cnt;
  int unsigned m_acc [2];
  bit          m_sat [2];
  int          e_cnt;
  int unsigned e_sum [2];
  bit          e_sat [2];

  always #5 clk = ~clk;

  mult4_prod_accum #(.PW(PW), .ACC_W(16), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_p(in_p), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .out_sat(a_out_sat));

  mult4_prod_accum #(.PW(PW), .ACC_W(9), .FRAME_LEN(FL)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_p(in_p), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_sat(b_out_sat));

  function automatic int unsigned maxv(int k);
    return (k == 0) ? 32'd65535 : 32'd511;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_cnt  = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_sat[k] = 0;
    end
  endtask

  // one clock of the frame rules, applied to the inputs present at the edge
  task automatic model_step();
    int unsigned s;
    if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      for (int k = 0; k < 2; k++) begin
        s = m_acc[k] + in_p;
        if (s > maxv(k)) begin
          s = maxv(k);
          m_sat[k] = 1;
        end
        m_acc[k] = s;
      end
      m_cnt++;
      if (in_last || m_cnt == FL) begin
        for (int k = 0; k < 2; k++) begin
          e_sum[k] = m_acc[k];
          e_sat[k] = m_sat[k];
          m_acc[k] = 0;
          m_sat[k] = 0;
        end
        e_cnt  = m_cnt;
        m_cnt  = 0;
        m_hold = 1;
      end
    end
  endtask

  task automatic compare();
    chk("a_in_ready", a_in_ready, !m_hold);
    chk("b_in_ready", b_in_ready, !m_hold);
    chk("a_out_valid", a_out_valid, m_hold);
    chk("b_out_valid", b_out_valid, m_hold);
    if (m_hold) begin
      chk("a_out_sum", a_out_sum, e_sum[0]);
      chk("a_out_count", a_out_count, e_cnt);
      chk("a_out_sat", a_out_sat, e_sat[0]);
      chk("b_out_sum", b_out_sum, e_sum[1]);
      chk("b_out_count", b_out_count, e_cnt);
      chk("b_out_sat", b_out_sat, e_sat[1]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    if (!rst) compare();
  endtask

  task automatic drive(bit v, int p, bit l, bit r);
    in_valid  = v;
    in_p      = PW'(p);
    in_last   = l;
    out_ready = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sum", a_out_sum, 0);
    rst = 1'b0;
    chk("rel_in_ready", a_in_ready, 1);
    cycle();

    // 225 + 6 + 36, last on the third
    drive(1, 225, 0, 0); cycle();
    drive(1, 6, 0, 0);   cycle();
    drive(1, 36, 1, 0);  cycle();
    chk("f3_valid", a_out_valid, 1);
    chk("f3_sum", a_out_sum, 267);
    chk("f3_count", a_out_count, 3);
    chk("f3_sat", a_out_sat, 0);
    drive(0, 0, 0, 1); cycle();

    // 16 x 225 with no last: closes on length
    for (int i = 0; i < 16; i++) begin
      drive(1, 225, 0, 0);
      cycle();
    end
    chk("f16_sum", a_out_sum, 3600);
    chk("f16_count", a_out_count, 16);
    chk("f16_b_sum", b_out_sum, 511);
    chk("f16_b_sat", b_out_sat, 1);
    // 17th product waits while the result is held
    for (int i = 0; i < 5; i++) begin
      drive(1, 5, 1, 0);
      cycle();
      chk("hold_in_ready", a_in_ready, 0);
      chk("hold_sum", a_out_sum, 3600);
    end
    drive(1, 5, 1, 1); cycle();
    chk("rel_in_ready2", a_in_ready, 1);
    drive(1, 5, 1, 0); cycle();
    chk("restart_sum", a_out_sum, 5);
    chk("restart_count", a_out_count, 1);
    drive(0, 0, 0, 1); cycle();

    // saturation in the 9-bit instance: 3 x 225 = 675 -> 511
    drive(1, 225, 0, 0); cycle();
    drive(1, 225, 0, 0); cycle();
    drive(1, 225, 1, 0); cycle();
    chk("sat_b_sum", b_out_sum, 511);
    chk("sat_b_flag", b_out_sat, 1);
    chk("sat_b_count", b_out_count, 3);
    chk("sat_a_sum", a_out_sum, 675);
    drive(0, 0, 0, 1); cycle();
    drive(1, 7, 1, 0); cycle();
    chk("after_sat_flag", b_out_sat, 0);
    chk("after_sat_sum", b_out_sum, 7);
    drive(0, 0, 0, 1); cycle();

    // zero-valued product still counts
    drive(1, 0, 0, 0); cycle();
    drive(1, 0, 1, 0); cycle();
    chk("zero_count", a_out_count, 2);
    chk("zero_sum", a_out_sum, 0);
    drive(0, 0, 0, 1); cycle();

    // async reset while holding a result, between clock edges
    drive(1, 9, 1, 0); cycle();
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_out_valid", a_out_valid, 0);
    chk("arst_out_sum", a_out_sum, 0);
    chk("arst_out_count", a_out_count, 0);
    chk("arst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // async reset mid-frame discards the partial sum
    drive(1, 50, 0, 0); cycle();
    cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 7, 1, 0); cycle();
    chk("mid_rst_sum", a_out_sum, 7);
    chk("mid_rst_count", a_out_count, 1);
    drive(0, 0, 0, 1); cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255)),
            ($urandom_range(0, 6) == 0), $urandom_range(0, 1));
      cycle();
    end
    drive(0, 0, 0, 1); cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
